// File: rtl/galaxian_pkg.sv
// rtl/galaxian_pkg.sv - shared hit-control types, key codes and default hit box sizes
package galaxian_pkg;

  typedef enum logic [1:0] {
    PLAY,
    INVULN,
    DYING,
    DEAD
  } hit_state_t;

  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_W     = 8'h1A;

  localparam int SHIP_W_DEF = 16;
  localparam int SHIP_H_DEF = 16;
  localparam int MSL_W_DEF  = 2;
  localparam int MSL_H_DEF  = 6;

  function automatic logic is_restart_key(input logic [7:0] key);
    return (key == KEY_ENTER) || (key == KEY_SPACE) || (key == KEY_W);
  endfunction

endpackage

// File: rtl/player_hit_ctrl_if.sv
// rtl/player_hit_ctrl_if.sv - ship/missile/status bundle for player_hit_ctrl (PLAYER_HIT_CONTACT_EN adds enemy_contact)
interface player_hit_ctrl_if #(
  parameter int NUM_MISSILES = 4
);
  logic [9:0]                ship_x;
  logic [9:0]                ship_y;
  logic [NUM_MISSILES*10-1:0] msl_x;
  logic [NUM_MISSILES*10-1:0] msl_y;
  logic [NUM_MISSILES-1:0]   msl_active;
  logic                      game_over;
  logic [15:0]               keycode;
  logic                      explode;
  logic [1:0]                lives;
  logic                      invuln;
  logic                      hit_pulse;
  logic [NUM_MISSILES-1:0]   msl_clear;
`ifdef PLAYER_HIT_CONTACT_EN
  logic                      enemy_contact;

  modport master (
    output ship_x, ship_y, msl_x, msl_y, msl_active, game_over, keycode, enemy_contact,
    input  explode, lives, invuln, hit_pulse, msl_clear
  );
  modport slave (
    input  ship_x, ship_y, msl_x, msl_y, msl_active, game_over, keycode, enemy_contact,
    output explode, lives, invuln, hit_pulse, msl_clear
  );
`else
  modport master (
    output ship_x, ship_y, msl_x, msl_y, msl_active, game_over, keycode,
    input  explode, lives, invuln, hit_pulse, msl_clear
  );
  modport slave (
    input  ship_x, ship_y, msl_x, msl_y, msl_active, game_over, keycode,
    output explode, lives, invuln, hit_pulse, msl_clear
  );
`endif
endinterface

// File: rtl/hit_box_cmp.sv
// rtl/hit_box_cmp.sv - combinational overlap test of one missile box against the ship box
module hit_box_cmp
  import galaxian_pkg::*;
#(
  parameter int SHIP_W = SHIP_W_DEF,
  parameter int SHIP_H = SHIP_H_DEF,
  parameter int MSL_W  = MSL_W_DEF,
  parameter int MSL_H  = MSL_H_DEF
) (
  input  logic [9:0] ship_x,
  input  logic [9:0] ship_y,
  input  logic [9:0] msl_x,
  input  logic [9:0] msl_y,
  input  logic       active,
  output logic       overlap
);

  // Sums are widened to 11 bits so boxes near the right/bottom edge never wrap to 0.
  logic [10:0] sx, sy, mx, my;

  always_comb begin
    sx = {1'b0, ship_x};
    sy = {1'b0, ship_y};
    mx = {1'b0, msl_x};
    my = {1'b0, msl_y};
    overlap = active
           && (mx + 11'(MSL_W) > sx) && (mx < sx + 11'(SHIP_W))
           && (my + 11'(MSL_H) > sy) && (my < sy + 11'(SHIP_H));
  end

endmodule

// File: rtl/player_hit_ctrl.sv
// rtl/player_hit_ctrl.sv - per-frame ship hit detection, lives, invulnerability and explode hand-off
// Optional: PLAYER_HIT_CONTACT_EN adds bus.enemy_contact as an extra hit source.
module player_hit_ctrl
  import galaxian_pkg::*;
#(
  parameter int NUM_MISSILES  = 4,
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int SHIP_W        = SHIP_W_DEF,
  parameter int SHIP_H        = SHIP_H_DEF,
  parameter int MSL_W         = MSL_W_DEF,
  parameter int MSL_H         = MSL_H_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_clk,
  player_hit_ctrl_if.slave bus
);

  localparam int CW = $clog2(INVULN_FRAMES + 1);

  hit_state_t              state;
  logic                    frame_clk_d;
  logic                    frame_tick;
  logic [CW-1:0]           cnt_q;
  logic [1:0]              lives_q;
  logic                    explode_q, invuln_q, hit_pulse_q;
  logic [NUM_MISSILES-1:0] clear_q;
  logic [NUM_MISSILES-1:0] overlap;
  logic                    any_hit;
  logic [7:0]              unused_key_hi;

  assign unused_key_hi = bus.keycode[15:8];
  assign frame_tick    = frame_clk & ~frame_clk_d;

  genvar i;
  for (i = 0; i < NUM_MISSILES; i++) begin : g_cmp
    hit_box_cmp #(
      .SHIP_W(SHIP_W),
      .SHIP_H(SHIP_H),
      .MSL_W (MSL_W),
      .MSL_H (MSL_H)
    ) u_cmp (
      .ship_x (bus.ship_x),
      .ship_y (bus.ship_y),
      .msl_x  (bus.msl_x[10*i +: 10]),
      .msl_y  (bus.msl_y[10*i +: 10]),
      .active (bus.msl_active[i]),
      .overlap(overlap[i])
    );
  end

`ifdef PLAYER_HIT_CONTACT_EN
  assign any_hit = (|overlap) | bus.enemy_contact;
`else
  assign any_hit = |overlap;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= PLAY;
      frame_clk_d <= 1'b0;
      cnt_q       <= '0;
      lives_q     <= 2'(START_LIVES);
      explode_q   <= 1'b0;
      invuln_q    <= 1'b0;
      hit_pulse_q <= 1'b0;
      clear_q     <= '0;
    end else begin
      frame_clk_d <= frame_clk;
      hit_pulse_q <= 1'b0;
      clear_q     <= '0;
      case (state)
        PLAY: begin
          // Multiple overlapping missiles in one frame cost a single life.
          if (frame_tick && any_hit) begin
            hit_pulse_q <= 1'b1;
            clear_q     <= overlap;
            if (lives_q > 2'd1) begin
              lives_q  <= lives_q - 2'd1;
              cnt_q    <= CW'(INVULN_FRAMES);
              invuln_q <= 1'b1;
              state    <= INVULN;
            end else begin
              lives_q   <= 2'd0;
              explode_q <= 1'b1;
              state     <= DYING;
            end
          end
        end
        INVULN: begin
          if (frame_tick) begin
            if (cnt_q <= CW'(1)) begin
              cnt_q    <= '0;
              invuln_q <= 1'b0;
              state    <= PLAY;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
        end
        DYING: begin
          // explode stays up until the slow-clocked sequencer acknowledges.
          if (bus.game_over) begin
            explode_q <= 1'b0;
            state     <= DEAD;
          end
        end
        DEAD: begin
          if (bus.game_over && is_restart_key(bus.keycode[7:0])) begin
            lives_q <= 2'(START_LIVES);
            state   <= PLAY;
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

  assign bus.explode   = explode_q;
  assign bus.lives     = lives_q;
  assign bus.invuln    = invuln_q;
  assign bus.hit_pulse = hit_pulse_q;
  assign bus.msl_clear = clear_q;

endmodule

// File: tb/tb_player_hit_ctrl.sv
// tb/tb_player_hit_ctrl.sv - scoreboard bench for player_hit_ctrl
`timescale 1ns/1ps
module tb_player_hit_ctrl;

  logic Clk = 1'b0;
  logic Reset;
  logic frame_clk;

  player_hit_ctrl_if #(.NUM_MISSILES(4)) bus ();

  player_hit_ctrl dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .frame_clk(frame_clk),
    .bus      (bus.slave)
  );

  always #5 Clk = ~Clk;

  // Expected observation: {hit_pulse, msl_clear[3:0], lives[1:0], invuln, explode}
  logic [8:0] exp_q[$];
  logic [8:0] e;
  logic [8:0] g;
  int checks = 0;
  int passes = 0;

  function automatic logic [8:0] obs();
    return {bus.hit_pulse, bus.msl_clear, bus.lives, bus.invuln, bus.explode};
  endfunction

  function automatic logic [8:0] mk(input logic hp, input logic [3:0] clr,
                                    input logic [1:0] lv, input logic inv, input logic ex);
    return {hp, clr, lv, inv, ex};
  endfunction

  task automatic set_msl(input int slot, input int x, input int y);
    bus.msl_x[10*slot +: 10] = 10'(x);
    bus.msl_y[10*slot +: 10] = 10'(y);
  endtask

  // Drive one frame strobe and queue what the outputs must read afterwards.
  task automatic tick(input logic [8:0] expect_v);
    exp_q.push_back(expect_v);
    @(posedge Clk); #1 frame_clk = 1'b1;
    @(posedge Clk); #1 frame_clk = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge Clk); #1 frame_clk = 1'b1;
      @(posedge Clk); #1 frame_clk = 1'b0;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    exp_q.push_back(mk(0, 4'b0000, 2'd3, 0, 0));
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    checks++; e = exp_q.pop_front(); g = obs();
    if (g !== e) $display("FAIL reset got=%b exp=%b", g, e); else passes++;
  endtask

  task automatic test_single_hit();
    bus.ship_x = 10'd95; bus.ship_y = 10'd195;
    set_msl(0, 100, 200);
    bus.msl_active = 4'b0001;
    tick(mk(1, 4'b0001, 2'd2, 1, 0));
    checks++; e = exp_q.pop_front(); g = obs();
    if (g !== e) $display("FAIL single_hit got=%b exp=%b", g, e); else passes++;
    exp_q.push_back(mk(0, 4'b0000, 2'd2, 1, 0));
    @(posedge Clk); #1;
    checks++; e = exp_q.pop_front(); g = obs();
    if (g !== e) $display("FAIL pulse_width got=%b exp=%b", g, e); else passes++;
  endtask

  task automatic test_invuln();
    for (int k = 1; k <= 119; k++) begin
      tick(mk(0, 4'b0000, 2'd2, 1, 0));
      checks++; e = exp_q.pop_front(); g = obs();
      if (g !== e) $display("FAIL invuln_tick%0d got=%b exp=%b", k, g, e); else passes++;
    end
    tick(mk(0, 4'b0000, 2'd2, 0, 0));
    checks++; e = exp_q.pop_front(); g = obs();
    if (g !== e) $display("FAIL invuln_end got=%b exp=%b", g, e); else passes++;
    bus.msl_active = 4'b0000;
  endtask

  task automatic test_multi_hit();
    set_msl(1, 96, 196);
    set_msl(2, 500, 500);
    set_msl(3, 108, 208);
    bus.msl_active = 4'b1110;
    tick(mk(1, 4'b1010, 2'd1, 1, 0));
    checks++; e = exp_q.pop_front(); g = obs();
    if (g !== e) $display("FAIL multi_hit got=%b exp=%b", g, e); else passes++;
    bus.msl_active = 4'b0000;
    idle_ticks(119);
    tick(mk(0, 4'b0000, 2'd1, 0, 0));
    checks++; e = exp_q.pop_front(); g = obs();
    if (g !== e) $display("FAIL multi_recover got=%b exp=%b", g, e); else passes++;
  endtask

  task automatic test_fatal();
    bus.msl_active = 4'b0001;
    tick(mk(1, 4'b0001, 2'd0, 0, 1));
    checks++; e = exp_q.pop_front(); g = obs();
    if (g !== e) $display("FAIL fatal_hit got=%b exp=%b", g, e); else passes++;
    bus.msl_active = 4'b0000;
    for (int k = 0; k < 50; k++) begin
      exp_q.push_back(mk(0, 4'b0000, 2'd0, 0, 1));
      @(posedge Clk); #1;
      checks++; e = exp_q.pop_front(); g = obs();
      if (g !== e) $display("FAIL explode_hold%0d got=%b exp=%b", k, g, e); else passes++;
    end
    bus.game_over = 1'b1;
    exp_q.push_back(mk(0, 4'b0000, 2'd0, 0, 0));
    @(posedge Clk); #1 bus.game_over = 1'b0;
    checks++; e = exp_q.pop_front(); g = obs();
    if (g !== e) $display("FAIL explode_fall got=%b exp=%b", g, e); else passes++;
  endtask

  task automatic test_dead_keys();
    bus.msl_active = 4'b0001;
    tick(mk(0, 4'b0000, 2'd0, 0, 0));
    checks++; e = exp_q.pop_front(); g = obs();
    if (g !== e) $display("FAIL dead_no_hit got=%b exp=%b", g, e); else passes++;
    bus.msl_active = 4'b0000;
    bus.game_over = 1'b1;
    bus.keycode = 16'h0004;
    exp_q.push_back(mk(0, 4'b0000, 2'd0, 0, 0));
    repeat (2) @(posedge Clk); #1;
    checks++; e = exp_q.pop_front(); g = obs();
    if (g !== e) $display("FAIL dead_bad_key got=%b exp=%b", g, e); else passes++;
    bus.keycode = 16'hFF2C;
    exp_q.push_back(mk(0, 4'b0000, 2'd3, 0, 0));
    @(posedge Clk); #1;
    bus.game_over = 1'b0;
    bus.keycode = 16'h0000;
    checks++; e = exp_q.pop_front(); g = obs();
    if (g !== e) $display("FAIL dead_restart got=%b exp=%b", g, e); else passes++;
  endtask

  task automatic test_no_wrap();
    bus.ship_x = 10'd0; bus.ship_y = 10'd100;
    set_msl(0, 1020, 100);
    bus.msl_active = 4'b0001;
    tick(mk(0, 4'b0000, 2'd3, 0, 0));
    checks++; e = exp_q.pop_front(); g = obs();
    if (g !== e) $display("FAIL no_wrap_miss got=%b exp=%b", g, e); else passes++;
    bus.ship_x = 10'd1010;
    tick(mk(1, 4'b0001, 2'd2, 1, 0));
    checks++; e = exp_q.pop_front(); g = obs();
    if (g !== e) $display("FAIL edge_hit got=%b exp=%b", g, e); else passes++;
    bus.msl_active = 4'b0000;
  endtask

  task automatic test_reset_dying();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    bus.ship_x = 10'd95; bus.ship_y = 10'd195;
    set_msl(0, 100, 200);
    for (int k = 0; k < 2; k++) begin
      bus.msl_active = 4'b0001;
      tick(mk(1, 4'b0001, 2'(2 - k), 1, 0));
      checks++; e = exp_q.pop_front(); g = obs();
      if (g !== e) $display("FAIL rd_hit%0d got=%b exp=%b", k, g, e); else passes++;
      bus.msl_active = 4'b0000;
      idle_ticks(120);
    end
    bus.msl_active = 4'b0001;
    tick(mk(1, 4'b0001, 2'd0, 0, 1));
    checks++; e = exp_q.pop_front(); g = obs();
    if (g !== e) $display("FAIL rd_fatal got=%b exp=%b", g, e); else passes++;
    bus.msl_active = 4'b0000;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    exp_q.push_back(mk(0, 4'b0000, 2'd3, 0, 0));
    @(posedge Clk); #1 Reset = 1'b0;
    checks++; e = exp_q.pop_front(); g = obs();
    if (g !== e) $display("FAIL reset_in_dying got=%b exp=%b", g, e); else passes++;
  endtask

  task automatic test_reset_tick();
    bus.msl_active = 4'b0001;
    Reset = 1'b1;
    frame_clk = 1'b1;
    exp_q.push_back(mk(0, 4'b0000, 2'd3, 0, 0));
    @(posedge Clk); #1;
    Reset = 1'b0;
    frame_clk = 1'b0;
    checks++; e = exp_q.pop_front(); g = obs();
    if (g !== e) $display("FAIL reset_beats_tick got=%b exp=%b", g, e); else passes++;
    tick(mk(1, 4'b0001, 2'd2, 1, 0));
    checks++; e = exp_q.pop_front(); g = obs();
    if (g !== e) $display("FAIL tick_after_reset got=%b exp=%b", g, e); else passes++;
    bus.msl_active = 4'b0000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d passed=%0d", checks, passes);
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    frame_clk = 1'b0;
    bus.ship_x = 10'd600;
    bus.ship_y = 10'd400;
    bus.msl_x = '0;
    bus.msl_y = '0;
    bus.msl_active = 4'b0000;
    bus.game_over = 1'b0;
    bus.keycode = 16'h0000;
`ifdef PLAYER_HIT_CONTACT_EN
    bus.enemy_contact = 1'b0;
`endif
    @(posedge Clk); #1;
    test_reset();
    test_single_hit();
    test_invuln();
    test_multi_hit();
    test_fatal();
    test_dead_keys();
    test_no_wrap();
    test_reset_dying();
    test_reset_tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
